// File: rtl/mcycle_unit_pkg.sv
// Shared op and state encodings for the iterative multiply/divide engine.
// The Decoder imports the same op encodings.
package mcycle_unit_pkg;

  typedef enum logic [1:0] {
    MC_SMUL = 2'b00,
    MC_UMUL = 2'b01,
    MC_SDIV = 2'b10,
    MC_UDIV = 2'b11
  } mc_op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_COMPUTE = 2'b01,
    S_DONE    = 2'b10
  } mc_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mcycle_negate_cond.sv
// Conditional two's-complement negate, purely combinational (zero latency, no flow control).
module mcycle_negate_cond #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_out
);

  assign o_out = i_neg ? -i_in : i_in;

endmodule

// File: rtl/mcycle_unit.sv
// Iterative signed/unsigned MUL/DIV: one step per cycle, results WIDTH+1 cycles after accept.
// Busy stalls the pipeline from the accept cycle through the last step; Done pulses for one cycle.
module mcycle_unit
  import mcycle_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH) + 1;

  mc_state_e          r_state, w_state_nxt;
  logic [1:0]         r_op;
  logic               r_neg_q, r_neg_r;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_shift;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_result1, r_result2;

  logic               w_s1, w_s2, w_accept, w_div0, w_last;
  logic [WIDTH-1:0]   w_mag1, w_mag2, w_quot, w_rem;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH+1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_step, w_prod;

  assign w_s1     = op_is_signed(MCycleOp) & Operand1[WIDTH-1];
  assign w_s2     = op_is_signed(MCycleOp) & Operand2[WIDTH-1];
  assign w_accept = (r_state == S_IDLE) && Start;
  assign w_div0   = op_is_div(MCycleOp) && (Operand2 == '0);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  mcycle_negate_cond #(.WIDTH(WIDTH)) u_mag1 (.i_neg(w_s1), .i_in(Operand1), .o_out(w_mag1));
  mcycle_negate_cond #(.WIDTH(WIDTH)) u_mag2 (.i_neg(w_s2), .i_in(Operand2), .o_out(w_mag2));

  // MUL: low half holds the multiplier, shifted right as the product grows in from the top.
  // DIV: low half holds the dividend, shifted left into the partial remainder; quotient bits enter at bit 0.
  assign w_mul_sum  = {1'b0, r_shift[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
  assign w_div_diff = {1'b0, r_shift[2*WIDTH-1:WIDTH-1]} - {2'b00, r_mcand};

  always_comb begin
    w_step = r_shift;
    if (op_is_div(r_op)) begin
      if (w_div_diff[WIDTH+1]) w_step = {r_shift[2*WIDTH-2:0], 1'b0};
      else                     w_step = {w_div_diff[WIDTH-1:0], r_shift[WIDTH-2:0], 1'b1};
    end else begin
      if (r_shift[0]) w_step = {w_mul_sum, r_shift[WIDTH-1:1]};
      else            w_step = {1'b0, r_shift[2*WIDTH-1:1]};
    end
  end

  mcycle_negate_cond #(.WIDTH(2*WIDTH)) u_fix_prod (.i_neg(r_neg_q), .i_in(w_step), .o_out(w_prod));
  mcycle_negate_cond #(.WIDTH(WIDTH)) u_fix_quot (.i_neg(r_neg_q), .i_in(w_step[WIDTH-1:0]), .o_out(w_quot));
  mcycle_negate_cond #(.WIDTH(WIDTH)) u_fix_rem (.i_neg(r_neg_r), .i_in(w_step[2*WIDTH-1:WIDTH]), .o_out(w_rem));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        Busy = Start & RESETn;
        if (Start) w_state_nxt = w_div0 ? S_DONE : S_COMPUTE;
      end
      S_COMPUTE: begin
        Busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        Done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_op      <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_mcand   <= '0;
      r_result1 <= '0;
      r_result2 <= '0;
    end else if (w_accept) begin
      r_op    <= MCycleOp;
      r_neg_q <= w_s1 ^ w_s2;
      r_neg_r <= w_s1;
      r_cnt   <= '0;
      r_mcand <= op_is_div(MCycleOp) ? w_mag2 : w_mag1;
      r_shift <= {{WIDTH{1'b0}}, (op_is_div(MCycleOp) ? w_mag1 : w_mag2)};
      if (w_div0) begin
        r_result1 <= '1;
        r_result2 <= Operand1;
      end
    end else if (r_state == S_COMPUTE) begin
      r_shift <= w_step;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_result1 <= op_is_div(r_op) ? w_quot : w_prod[WIDTH-1:0];
        r_result2 <= op_is_div(r_op) ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign Result1 = r_result1;
  assign Result2 = r_result2;

endmodule

// File: tb/tb_mcycle_unit.sv
// Scoreboard bench for mcycle_unit: 32-bit directed vectors plus an 8-bit instance against a golden model.
module tb_mcycle_unit;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        start32, start8;
  logic [1:0]  op32, op8;
  logic [31:0] a32, b32, r1_32, r2_32;
  logic [7:0]  a8, b8, r1_8, r2_8;
  logic        busy32, done32, busy8, done8;

  always #5 CLK = ~CLK;

  mcycle_unit #(.WIDTH(32)) dut32 (
    .CLK(CLK), .RESETn(RESETn), .Start(start32), .MCycleOp(op32),
    .Operand1(a32), .Operand2(b32), .Result1(r1_32), .Result2(r2_32),
    .Busy(busy32), .Done(done32)
  );

  mcycle_unit #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RESETn(RESETn), .Start(start8), .MCycleOp(op8),
    .Operand1(a8), .Operand2(b8), .Result1(r1_8), .Result2(r2_8),
    .Busy(busy8), .Done(done8)
  );

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    int          blen;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitors: compare whenever Done is presented; Busy run length is measured since the last Done.
  int   bc32 = 0, bc8 = 0;
  logic pd32 = 1'b0, pd8 = 1'b0;
  exp_t e32, e8;

  always @(negedge CLK) begin
    if (!RESETn) begin
      bc32 = 0;
      pd32 = 1'b0;
    end else begin
      if (done32) begin
        check("w32_done_single_cycle", 64'(pd32), 64'(0));
        check("w32_busy_low_at_done", 64'(busy32), 64'(0));
        if (q32.size() == 0) begin
          check("w32_unexpected_done", 64'(done32), 64'(0));
        end else begin
          e32 = q32.pop_front();
          check("w32_result1", 64'(r1_32), 64'(e32.r1));
          check("w32_result2", 64'(r2_32), 64'(e32.r2));
          check("w32_busy_cycles", 64'(bc32), 64'(e32.blen));
        end
        bc32 = 0;
      end else if (busy32) begin
        bc32++;
      end
      pd32 = done32;
    end
  end

  always @(negedge CLK) begin
    if (!RESETn) begin
      bc8 = 0;
      pd8 = 1'b0;
    end else begin
      if (done8) begin
        check("w8_done_single_cycle", 64'(pd8), 64'(0));
        if (q8.size() == 0) begin
          check("w8_unexpected_done", 64'(done8), 64'(0));
        end else begin
          e8 = q8.pop_front();
          check("w8_result1", 64'(r1_8), 64'(e8.r1));
          check("w8_result2", 64'(r2_8), 64'(e8.r2));
          check("w8_busy_cycles", 64'(bc8), 64'(e8.blen));
        end
        bc8 = 0;
      end else if (busy8) begin
        bc8++;
      end
      pd8 = done8;
    end
  end

  task automatic wait_done(input bit wide);
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      if (wide ? done32 : done8) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_200_cycles");
    end
  endtask

  task automatic push32(input logic [31:0] e1, input logic [31:0] e2, input int bl);
    exp_t e;
    e.r1 = e1;
    e.r2 = e2;
    e.blen = bl;
    q32.push_back(e);
  endtask

  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e1, input logic [31:0] e2, input int bl);
    @(posedge CLK);
    #1;
    op32 = o; a32 = x; b32 = y; start32 = 1'b1;
    push32(e1, e2, bl);
    @(posedge CLK);
    #1;
    start32 = 1'b0;
    wait_done(1'b1);
  endtask

  function automatic logic [15:0] gold8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    longint sx, sy, p, q, r;
    sx = o[0] ? longint'(x) : longint'($signed(x));
    sy = o[0] ? longint'(y) : longint'($signed(y));
    if (!o[1]) begin
      p = sx * sy;
      return p[15:0];
    end
    if (y == 8'h00) return {x, 8'hFF};
    q = sx / sy;
    r = sx % sy;
    return {r[7:0], q[7:0]};
  endfunction

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t        e;
    logic [15:0] g;
    g = gold8(o, x, y);
    e.r1 = 32'(g[7:0]);
    e.r2 = 32'(g[15:8]);
    e.blen = (o[1] && y == 8'h00) ? 1 : 9;
    @(posedge CLK);
    #1;
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    q8.push_back(e);
    @(posedge CLK);
    #1;
    start8 = 1'b0;
    wait_done(1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog");
  end

  logic [7:0] xs [6];
  logic [7:0] ys [5];

  initial begin
    xs = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h05, 8'hC3};
    ys = '{8'h03, 8'hFF, 8'h80, 8'h00, 8'h7F};
    RESETn = 1'b0;
    start32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
    start8 = 1'b0;  op8 = 2'b00;  a8 = '0;  b8 = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_result1", 64'(r1_32), 64'(0));
    check("reset_result2", 64'(r2_32), 64'(0));
    check("reset_busy", 64'(busy32), 64'(0));
    check("reset_done", 64'(done32), 64'(0));
    RESETn = 1'b1;

    run32(2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 33);
    run32(2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 33);
    run32(2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'h00000006, 33);
    run32(2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 33);
    run32(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    run32(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 33);
    run32(2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run32(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33);
    run32(2'b11, 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 1);
    run32(2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1);

    // Operands and Start disturbed mid-compute must not affect the latched operation.
    @(posedge CLK);
    #1;
    op32 = 2'b01; a32 = 32'h00001000; b32 = 32'h00001000; start32 = 1'b1;
    push32(32'h01000000, 32'h00000000, 33);
    @(posedge CLK);
    #1 start32 = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    op32 = 2'b10; a32 = 32'hFFFFFFFF; b32 = 32'h00000000; start32 = 1'b1;
    @(posedge CLK);
    #1 start32 = 1'b0;
    @(posedge CLK);
    #1 start32 = 1'b1;
    @(posedge CLK);
    #1 start32 = 1'b0;
    wait_done(1'b1);

    // Reset ten cycles into a multiply, then restart with Start held through release.
    @(posedge CLK);
    #1;
    op32 = 2'b01; a32 = 32'h12345678; b32 = 32'h00000010; start32 = 1'b1;
    push32(32'h23456780, 32'h00000001, 33);
    @(posedge CLK);
    #1 start32 = 1'b0;
    repeat (9) @(posedge CLK);
    #1 RESETn = 1'b0;
    #1;
    check("midreset_busy", 64'(busy32), 64'(0));
    check("midreset_done", 64'(done32), 64'(0));
    check("midreset_result1", 64'(r1_32), 64'(0));
    check("midreset_result2", 64'(r2_32), 64'(0));
    q32.delete();
    push32(32'h23456780, 32'h00000001, 33);
    start32 = 1'b1;
    @(posedge CLK);
    #1 RESETn = 1'b1;
    @(posedge CLK);
    #1 start32 = 1'b0;
    wait_done(1'b1);

    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 5; j++)
        for (int k = 0; k < 4; k++)
          run8(2'(k), xs[i], ys[j]);

    repeat (3) @(posedge CLK);
    check("w32_queue_drained", 64'(q32.size()), 64'(0));
    check("w8_queue_drained", 64'(q8.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
